// File: rtl/pixel_top_ctrl.sv
// Frame sequencer and behavioural model of a 2x2 pixel sensor with per-pixel
// single-slope ADC, driving a shared tri-state readout bus.
module pixel_top_ctrl #(
  parameter int unsigned ERASE_CYCLES  = 5,
  parameter int unsigned EXPOSE_CYCLES = 255,
  parameter int unsigned READ_CYCLES   = 5,
  parameter logic [7:0]  PIX0_LEVEL    = 8'd10,
  parameter logic [7:0]  PIX1_LEVEL    = 8'd100,
  parameter logic [7:0]  PIX2_LEVEL    = 8'd200,
  parameter logic [7:0]  PIX3_LEVEL    = 8'd255
) (
  input  logic       clk,
  input  logic       reset,
  output logic       anaBias1,
  output logic       anaRamp,
  output logic       erase,
  output logic       expose,
  output logic       read0,
  output logic       read1,
  output logic       read2,
  output logic       read3,
  output logic       convert,
  inout  tri   [7:0] pixData
);

  typedef enum logic [2:0] {
    IDLE, ERASE, EXPOSE, CONVERT, READ0, READ1, READ2, READ3
  } state_t;

  state_t     state_q, state_d;
  logic [8:0] cnt_q, cnt_d;
  logic [8:0] last_cnt;

  logic       erase_q, erase_d;
  logic       expose_q, expose_d;
  logic       convert_q, convert_d;
  logic [3:0] read_q, read_d;

  logic [7:0] ramp_q, ramp_d;
  logic [7:0] res_q [4];
  logic [7:0] res_d [4];
  logic [3:0] hit_q, hit_d;
  logic [7:0] level [4];
  logic [7:0] bus_val;

  assign level[0] = PIX0_LEVEL;
  assign level[1] = PIX1_LEVEL;
  assign level[2] = PIX2_LEVEL;
  assign level[3] = PIX3_LEVEL;

  // IDLE exits on count 1: the reset edge itself is counted, so exactly one
  // IDLE cycle is seen after release before ERASE.
  always_comb begin
    case (state_q)
      IDLE:    last_cnt = 9'd1;
      ERASE:   last_cnt = 9'(ERASE_CYCLES - 1);
      EXPOSE:  last_cnt = 9'(EXPOSE_CYCLES - 1);
      CONVERT: last_cnt = 9'd255;
      default: last_cnt = 9'(READ_CYCLES - 1);
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 9'd1;
    if (cnt_q == last_cnt) begin
      cnt_d = '0;
      case (state_q)
        IDLE:    state_d = ERASE;
        ERASE:   state_d = EXPOSE;
        EXPOSE:  state_d = CONVERT;
        CONVERT: state_d = READ0;
        READ0:   state_d = READ1;
        READ1:   state_d = READ2;
        READ2:   state_d = READ3;
        READ3:   state_d = ERASE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state so they switch on the same edge.
  always_comb begin
    erase_d   = (state_d == ERASE);
    expose_d  = (state_d == EXPOSE);
    convert_d = (state_d == CONVERT);
    read_d    = {state_d == READ3, state_d == READ2,
                 state_d == READ1, state_d == READ0};
  end

  always_comb begin
    if (state_q != CONVERT)
      ramp_d = '0;
    else if (ramp_q != 8'hFF)
      ramp_d = ramp_q + 8'd1;
    else
      ramp_d = ramp_q;
  end

  always_comb begin
    hit_d = hit_q;
    for (int unsigned i = 0; i < 4; i++) begin
      res_d[i] = res_q[i];
      if (state_q == ERASE) begin
        res_d[i] = '0;
        hit_d[i] = 1'b0;
      end else if (state_q == CONVERT && !hit_q[i] && ramp_q == level[i]) begin
        res_d[i] = ramp_q;
        hit_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      erase_q   <= 1'b0;
      expose_q  <= 1'b0;
      convert_q <= 1'b0;
      read_q    <= '0;
      ramp_q    <= '0;
      hit_q     <= '0;
      for (int unsigned i = 0; i < 4; i++) res_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      erase_q   <= erase_d;
      expose_q  <= expose_d;
      convert_q <= convert_d;
      read_q    <= read_d;
      ramp_q    <= ramp_d;
      hit_q     <= hit_d;
      for (int unsigned i = 0; i < 4; i++) res_q[i] <= res_d[i];
    end
  end

  always_comb begin
    bus_val = '0;
    for (int unsigned i = 0; i < 4; i++)
      if (read_q[i]) bus_val = res_q[i];
  end

  assign pixData  = (|read_q) ? bus_val : 'z;

  assign erase    = erase_q;
  assign expose   = expose_q;
  assign anaBias1 = expose_q;
  assign convert  = convert_q;
  assign anaRamp  = convert_q;
  assign read0    = read_q[0];
  assign read1    = read_q[1];
  assign read2    = read_q[2];
  assign read3    = read_q[3];

endmodule

// File: tb/tb_pixel_top_ctrl.sv
// Cycle-by-cycle check of two sensor instances (default and overridden
// parameters) against a frame-position model, with randomized reset pulses.
module tb_pixel_top_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic       a_bias, a_ramp, a_erase, a_expose, a_conv, a_r0, a_r1, a_r2, a_r3;
  logic       b_bias, b_ramp, b_erase, b_expose, b_conv, b_r0, b_r1, b_r2, b_r3;
  tri   [7:0] bus_a;
  tri   [7:0] bus_b;

  pixel_top_ctrl dut_a (
    .clk(clk), .reset(reset), .anaBias1(a_bias), .anaRamp(a_ramp),
    .erase(a_erase), .expose(a_expose), .read0(a_r0), .read1(a_r1),
    .read2(a_r2), .read3(a_r3), .convert(a_conv), .pixData(bus_a)
  );

  pixel_top_ctrl #(
    .READ_CYCLES(2), .PIX0_LEVEL(8'd0), .PIX3_LEVEL(8'd128)
  ) dut_b (
    .clk(clk), .reset(reset), .anaBias1(b_bias), .anaRamp(b_ramp),
    .erase(b_erase), .expose(b_expose), .read0(b_r0), .read1(b_r1),
    .read2(b_r2), .read3(b_r3), .convert(b_conv), .pixData(bus_b)
  );

  int errors = 0;
  int checks = 0;
  int e_rel  = 0;  // rising edges seen with reset high since last reset edge

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %h, expected %h", tag, e_rel, got, exp);
    end
  endtask

  // Expected {anaBias1,anaRamp,erase,expose,convert,read0..read3,pixData}
  // from the position inside the repeating frame.
  function automatic logic [16:0] model(input int e, input int er, input int ex,
                                        input int rd, input logic [7:0] l0,
                                        input logic [7:0] l1, input logic [7:0] l2,
                                        input logic [7:0] l3);
    logic [8:0] s;
    logic [7:0] d;
    logic [7:0] lv [4];
    int q, slot;
    lv[0] = l0; lv[1] = l1; lv[2] = l2; lv[3] = l3;
    s = '0;
    d = 'z;
    if (e >= 2) begin
      q = (e - 2) % (er + ex + 256 + 4 * rd);
      if (q < er) s[6] = 1'b1;
      else if (q < er + ex) begin s[8] = 1'b1; s[5] = 1'b1; end
      else if (q < er + ex + 256) begin s[7] = 1'b1; s[4] = 1'b1; end
      else begin
        slot = (q - er - ex - 256) / rd;
        s[3 - slot] = 1'b1;
        d = lv[slot];
      end
    end
    return {s, d};
  endfunction

  always @(posedge clk) begin
    if (!reset) e_rel = 0;
    else        e_rel++;
    #1;
    check("dutA", {15'd0, a_bias, a_ramp, a_erase, a_expose, a_conv,
                   a_r0, a_r1, a_r2, a_r3, bus_a},
          {15'd0, model(e_rel, 5, 255, 5, 8'd10, 8'd100, 8'd200, 8'd255)});
    check("dutB", {15'd0, b_bias, b_ramp, b_erase, b_expose, b_conv,
                   b_r0, b_r1, b_r2, b_r3, bus_b},
          {15'd0, model(e_rel, 5, 255, 2, 8'd0, 8'd100, 8'd200, 8'd128)});
  end

  initial begin
    int target;
    logic reached;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;

    // Second frame of dut_a, somewhere inside CONVERT.
    target = 2 + 536 + 260 + int'($urandom_range(0, 254));
    reached = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (e_rel >= target) begin
        reached = 1'b1;
        break;
      end
    end
    check("convert_reach", {31'd0, reached}, 32'd1);
    reset = 1'b0;
    repeat ($urandom_range(1, 3)) @(negedge clk);
    reset = 1'b1;
    repeat (2 * 536 + 40) @(negedge clk);

    for (int p = 0; p < 2; p++) begin
      repeat ($urandom_range(50, 600)) @(negedge clk);
      reset = 1'b0;
      repeat ($urandom_range(1, 2)) @(negedge clk);
      reset = 1'b1;
    end
    repeat (600) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pixel_top_ctrl.md
# pixel_top_ctrl

Top-level controller and digital model of a 2x2 pixel sensor with per-pixel 8-bit single-slope ADC. Sequences each frame through erase, exposure, ramp conversion and a four-slot readout, and drives the shared tri-state 8-bit pixel data bus. Sits at the top of the sensor hierarchy, between the analog pixel array (modelled here by fixed per-pixel light levels) and the downstream readout logic on `pixData`.

## Interface
- `ERASE_CYCLES`, default 5: cycles spent in ERASE.
- `EXPOSE_CYCLES`, default 255: cycles spent in EXPOSE.
- `READ_CYCLES`, default 5: cycles each read strobe is held.
- `PIX0_LEVEL`..`PIX3_LEVEL`, defaults 8'd10, 8'd100, 8'd200, 8'd255: modelled light level (comparator trip code) of pixels 0..3.
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `anaBias1`  out  1  pixel bias enable (high during EXPOSE).
- `anaRamp`  out  1  ADC ramp enable (high during CONVERT).
- `erase`  out  1  high during ERASE.
- `expose`  out  1  high during EXPOSE.
- `read0`..`read3`  out  1 each  read strobe for pixel 0..3; at most one high at a time.
- `convert`  out  1  high during CONVERT.
- `pixData`  inout (tri)  8  pixel data bus; driven only while a read strobe is high, else high-Z.

## Operation
- FSM states: IDLE, ERASE, EXPOSE, CONVERT, READ0, READ1, READ2, READ3.
- IDLE lasts 1 cycle -> ERASE (ERASE_CYCLES) -> EXPOSE (EXPOSE_CYCLES) -> CONVERT (256 cycles) -> READ0..READ3 (READ_CYCLES each) -> ERASE; repeats indefinitely.
- One 9-bit state-duration counter cleared on every state entry; exit when counter == duration-1.
- Outputs are registered and decoded one-hot from state: `erase`=ERASE, `expose`=`anaBias1`=EXPOSE, `convert`=`anaRamp`=CONVERT, `readN`=READN. All low in IDLE.
- ADC: 8-bit ramp counter, 0 on CONVERT entry, +1 per CONVERT cycle, value n on the n-th CONVERT cycle (0-based), reaches 255 on last cycle; no wrap.
- Per-pixel 8-bit result register: cleared during ERASE; during CONVERT, pixel i latches the ramp counter on the cycle it equals PIXi_LEVEL (comparator trip); latches once per frame. Hence result_i = PIXi_LEVEL after CONVERT.
- pixData = result_i while `read_i` high; high-Z otherwise. Never driven in any other state.
- Frame length with defaults: 5+255+256+20 = 536 cycles, plus 1 IDLE cycle after reset.

## Timing
- Reset (`reset`==0 at a rising edge): state IDLE, counters 0, result registers 0, all outputs 0, pixData high-Z from that edge; holds while reset low.
- First edge with `reset`==1: IDLE; next edge enters ERASE (`erase` high 1 cycle after reset release + 1).
- State transitions and output changes occur on the same rising edge (no extra output latency).
- Reset asserted mid-frame (any state): aborts on that edge, outputs 0, bus released; restart from IDLE.
- Read strobes are back-to-back: `read0` falls on the same edge `read1` rises; bus switches driver without a high-Z gap; `read3` falling coincides with `erase` rising.
- PIXi_LEVEL=0 trips on first CONVERT cycle; 255 on last CONVERT cycle; both must latch correctly.

## Test plan
- Reset low 2 cycles then high -> all outputs 0 and pixData == 8'hZZ during reset; `erase` high for exactly 5 cycles starting 2nd edge after release.
- Full frame with defaults -> `expose`/`anaBias1` high 255 cycles, `convert`/`anaRamp` high 256 cycles, each readN high 5 cycles, in order read0..read3.
- Readout values -> pixData == 10, 100, 200, 255 during read0..read3; high-Z in all other states.
- Second frame -> same values, `erase` re-asserted immediately after `read3`; results cleared to 0 during ERASE.
- Reset pulse mid-CONVERT -> all outputs 0, bus high-Z next edge; restart reproduces full frame timing and values.
- Parameter override PIX0_LEVEL=0, PIX3_LEVEL=8'd128, READ_CYCLES=2 -> pixData reads 0 and 128 in slots 0 and 3; each strobe 2 cycles.
